// File: rtl/bit_encoder_if.sv
// Transmit-side handshake between a data source and an encoder stage.
// With BY_BYTE=0 the data member carries a single bit.
interface tx_interface #(
   parameter int BY_BYTE = 0
);
   localparam int DW = (BY_BYTE != 0) ? 8 : 1;

   logic [DW-1:0] data;
   logic          data_valid;
   logic          req;

   modport source (output data, output data_valid, input req);
   modport sink   (input data, input data_valid, output req);
endinterface

// File: rtl/bit_encoder.sv
// Manchester bit encoder, 128 clk per bit: first half drives the bit, second half its complement.
// Pulses req at mid-bit to ask for the next bit, and last_tick one cycle before the bit ends.
module bit_encoder (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      en,
   tx_interface.sink in_iface,
   output logic      encoded_data,
   output logic      last_tick
);
   localparam logic [6:0] REQ_TICK  = 7'd64;
   localparam logic [6:0] LAST_TICK = 7'd126;
   localparam logic [6:0] WRAP_TICK = 7'd127;

   logic [6:0] c, c_nxt;
   logic       b, b_nxt;
   logic       active;
   logic       req_q;

   assign in_iface.req = req_q;

   // a new bit is taken on the first enabled edge and on every 127->0 wrap
   always_comb begin
      c_nxt = '0;
      b_nxt = b;
      if (!active) begin
         b_nxt = in_iface.data[0];
      end else begin
         c_nxt = c + 7'd1;
         if (c == WRAP_TICK) b_nxt = in_iface.data[0];
      end
   end

   // outputs are decoded from c_nxt so they line up with the counter they describe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active       <= 1'b0;
         c            <= '0;
         b            <= 1'b0;
         encoded_data <= 1'b0;
         req_q        <= 1'b0;
         last_tick    <= 1'b0;
      end else if (!en) begin
         active       <= 1'b0;
         c            <= '0;
         b            <= 1'b0;
         encoded_data <= 1'b0;
         req_q        <= 1'b0;
         last_tick    <= 1'b0;
      end else begin
         active       <= 1'b1;
         c            <= c_nxt;
         b            <= b_nxt;
         encoded_data <= c_nxt[6] ? ~b_nxt : b_nxt;
         req_q        <= (c_nxt == REQ_TICK);
         last_tick    <= (c_nxt == LAST_TICK);
      end
   end
endmodule

// File: tb/tb_bit_encoder.sv
// Self-checking bench for bit_encoder: directed frames, random frames with aborts,
// and mid-frame reset, all compared against a per-sample Manchester reference.
module tb_bit_encoder;
   logic clk = 1'b0;
   logic rst_n;
   logic en;
   logic encoded_data;
   logic last_tick;

   int vectors = 0;
   int errs    = 0;

   tx_interface #(.BY_BYTE(0)) tx_if ();

   bit_encoder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .in_iface     (tx_if),
      .encoded_data (encoded_data),
      .last_tick    (last_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic got, input logic exp);
      vectors++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, " enc"},  encoded_data, 1'b0);
      chk({tag, " req"},  tx_if.req,    1'b0);
      chk({tag, " last"}, last_tick,    1'b0);
   endtask

   // Sample k after the first enabled edge belongs to bit k/128, phase k%128.
   // abort_k >= 0 drops en after that many samples.
   task automatic run_frame(input int n, input int abort_k, input logic [79:0] pat);
      int total;
      int stop;
      int bi;
      int ph;
      logic bit_v;
      total = 128 * n;
      stop  = (abort_k >= 0 && abort_k < total) ? abort_k : total;
      tx_if.data[0]    = pat[0];
      tx_if.data_valid = 1'b1;
      en = 1'b1;
      for (int k = 0; k < stop; k++) begin
         @(posedge clk);
         #1;
         bi    = k / 128;
         ph    = k % 128;
         bit_v = pat[bi];
         chk($sformatf("enc k=%0d", k),  encoded_data, (ph >= 64) ? ~bit_v : bit_v);
         chk($sformatf("req k=%0d", k),  tx_if.req,    ph == 64);
         chk($sformatf("last k=%0d", k), last_tick,    ph == 126);
         // source reacts to mid-bit request by presenting the next bit
         if (ph == 64 && bi + 1 < n) tx_if.data[0] = pat[bi+1];
      end
      en = 1'b0;
      tx_if.data[0]    = 1'($urandom);
      tx_if.data_valid = 1'b0;
      @(posedge clk);
      #1;
      chk_idle("after_en_low");
   endtask

   initial begin
      logic [79:0] pat;
      int n;
      int ab;

      rst_n = 1'b0;
      en    = 1'b0;
      tx_if.data       = '0;
      tx_if.data_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_idle("reset");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk_idle("idle_after_reset");
      end

      run_frame(1, -1, 80'h0);
      run_frame(1, -1, 80'h1);
      run_frame(2, -1, 80'b01);

      for (int f = 0; f < 15; f++) begin
         n   = $urandom_range(1, 16);
         pat = {16'($urandom), $urandom, $urandom};
         ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 128 * n - 1)) : -1;
         run_frame(n, ab, pat);
      end

      // asynchronous reset in the middle of a bit, en held high throughout
      en = 1'b1;
      tx_if.data[0] = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_idle("async_reset");
      @(posedge clk);
      #1;
      chk_idle("in_reset");
      rst_n = 1'b1;
      pat = {16'($urandom), $urandom, $urandom};
      run_frame(3, -1, pat);

      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         chk_idle("final_idle");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule
